test_engine_edge_endpoint: RTL

//  Boundary endpoint for one open edge port of the test-engine node mesh. Holds the far end of the channel/credit protocol.
//  TX side: buffers host flits, injects them into the node inport, and spends credits.
//  RX side: sinks flits leaving the node outport and returns one credit per flit.
//  One instance attaches to each xpos/xneg/ypos/yneg slice of the network core.

---
 rtl/test_engine_edge_endpoint.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/test_engine_edge_endpoint.sv
// rtl/test_engine_edge_endpoint.sv - open-edge endpoint of the test-engine mesh channel/credit protocol
//
// Terminates one xpos/xneg/ypos/yneg edge of the node mesh.
//   TX: host flits are queued in a small FIFO and injected into the node inport,
//       one flit per cycle while the credit counter is non-zero.
//   RX: flits leaving the node outport are registered for the host and each one
//       returns a single credit pulse to the node.
//
// Ports:
//   clk                clock, all logic on posedge
//   reset              synchronous, active-low
//   host_flit_din      flit from host (MSB is the flit valid bit)
//   host_valid_din     host flit valid
//   host_ready_dout    TX FIFO can accept a flit
//   channel_dout       flit to node channel input (all zero when idle)
//   credit_in_din      credit pulse from node
//   channel_din        flit from node channel output
//   credit_out_dout    credit pulse to node, one per received flit
//   rx_flit_dout       last received flit
//   rx_valid_dout      1-cycle strobe, rx_flit_dout is new
//   rx_tail_dout       received flit is a packet tail
//   tx_pkt_count_dout  tail flits injected (wrapping)
//   rx_pkt_count_dout  tail flits received (wrapping)
//   credit_err_dout    sticky: credit returned while counter was already full

`ifndef CHANNEL_WIDTH
`define CHANNEL_WIDTH 16
`endif

module test_engine_edge_endpoint #(
  parameter int BUFFER_DEPTH = 4,
  parameter int FIFO_DEPTH   = 8,
  parameter int PKT_FLITS    = 4,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [`CHANNEL_WIDTH-1:0] host_flit_din,
  input  logic                      host_valid_din,
  output logic                      host_ready_dout,
  output logic [`CHANNEL_WIDTH-1:0] channel_dout,
  input  logic                      credit_in_din,
  input  logic [`CHANNEL_WIDTH-1:0] channel_din,
  output logic                      credit_out_dout,
  output logic [`CHANNEL_WIDTH-1:0] rx_flit_dout,
  output logic                      rx_valid_dout,
  output logic                      rx_tail_dout,
  output logic [CNT_WIDTH-1:0]      tx_pkt_count_dout,
  output logic [CNT_WIDTH-1:0]      rx_pkt_count_dout,
  output logic                      credit_err_dout
);

  localparam int CW  = `CHANNEL_WIDTH;
  localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CRW = $clog2(BUFFER_DEPTH + 1);
  localparam int IW  = (PKT_FLITS > 1) ? $clog2(PKT_FLITS) : 1;

  localparam logic [IW-1:0]  LAST_IDX   = IW'(PKT_FLITS - 1);
  localparam logic [IW-1:0]  IDX_ONE    = IW'(1);
  localparam logic [CRW-1:0] CREDIT_MAX = CRW'(BUFFER_DEPTH);
  localparam logic [CRW-1:0] CREDIT_ONE = CRW'(1);
  localparam logic [AW:0]    FIFO_FULL  = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW:0]    CNT_ONE    = (AW + 1)'(1);
  localparam logic [AW-1:0]  PTR_ONE    = AW'(1);

  typedef enum logic { TX_IDLE, TX_BODY } tx_state_t;
  typedef enum logic { RX_IDLE, RX_BODY } rx_state_t;

  // TX FIFO; flushing only needs the pointers and count, so storage has no reset
  logic [CW-1:0] fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   fifo_count;
  logic [CRW-1:0] credit_count;

  logic push, inject, fifo_empty;

  tx_state_t     tx_state, tx_state_nxt;
  logic [IW-1:0] tx_idx, tx_idx_nxt;
  logic          tx_tail;

  rx_state_t     rx_state, rx_state_nxt;
  logic [IW-1:0] rx_idx, rx_idx_nxt;
  logic          rx_tail;
  logic          rx_in;

  // Ready is forced low during reset; it deliberately ignores a same-cycle pop
  assign host_ready_dout = reset && (fifo_count != FIFO_FULL);
  assign fifo_empty      = (fifo_count == '0);
  assign push            = host_valid_din && host_ready_dout;
  assign inject          = !fifo_empty && (credit_count != '0);
  assign rx_in           = channel_din[CW-1];

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= host_flit_din;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      fifo_count        <= '0;
      credit_count      <= CREDIT_MAX;
      credit_err_dout   <= 1'b0;
      channel_dout      <= '0;
      tx_pkt_count_dout <= '0;
      tx_state          <= TX_IDLE;
      tx_idx            <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (inject) rd_ptr <= rd_ptr + PTR_ONE;
      if (push && !inject) fifo_count <= fifo_count + CNT_ONE;
      else if (inject && !push) fifo_count <= fifo_count - CNT_ONE;

      // Non-inject cycles drive zero so every flit occupies exactly one cycle
      channel_dout <= inject ? fifo_mem[rd_ptr] : '0;

      if (inject && !credit_in_din) begin
        credit_count <= credit_count - CREDIT_ONE;
      end else if (credit_in_din && !inject) begin
        if (credit_count == CREDIT_MAX) credit_err_dout <= 1'b1;
        else credit_count <= credit_count + CREDIT_ONE;
      end

      if (tx_tail) tx_pkt_count_dout <= tx_pkt_count_dout + CNT_WIDTH'(1);
      tx_state <= tx_state_nxt;
      tx_idx   <= tx_idx_nxt;
    end
  end

  always_comb begin
    tx_state_nxt = tx_state;
    tx_idx_nxt   = tx_idx;
    tx_tail      = 1'b0;
    case (tx_state)
      TX_IDLE: if (inject) begin
        // Single-flit packets: the header is also the tail
        if (LAST_IDX == '0) begin
          tx_tail = 1'b1;
        end else begin
          tx_state_nxt = TX_BODY;
          tx_idx_nxt   = IDX_ONE;
        end
      end
      TX_BODY: if (inject) begin
        if (tx_idx == LAST_IDX) begin
          tx_tail      = 1'b1;
          tx_state_nxt = TX_IDLE;
          tx_idx_nxt   = '0;
        end else begin
          tx_idx_nxt = tx_idx + IDX_ONE;
        end
      end
      default: begin
        tx_state_nxt = TX_IDLE;
        tx_idx_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_flit_dout      <= '0;
      rx_valid_dout     <= 1'b0;
      rx_tail_dout      <= 1'b0;
      credit_out_dout   <= 1'b0;
      rx_pkt_count_dout <= '0;
      rx_state          <= RX_IDLE;
      rx_idx            <= '0;
    end else begin
      rx_valid_dout   <= rx_in;
      credit_out_dout <= rx_in;
      rx_tail_dout    <= rx_tail;
      if (rx_in) rx_flit_dout <= channel_din;
      if (rx_tail) rx_pkt_count_dout <= rx_pkt_count_dout + CNT_WIDTH'(1);
      rx_state <= rx_state_nxt;
      rx_idx   <= rx_idx_nxt;
    end
  end

  always_comb begin
    rx_state_nxt = rx_state;
    rx_idx_nxt   = rx_idx;
    rx_tail      = 1'b0;
    case (rx_state)
      RX_IDLE: if (rx_in) begin
        if (LAST_IDX == '0) begin
          rx_tail = 1'b1;
        end else begin
          rx_state_nxt = RX_BODY;
          rx_idx_nxt   = IDX_ONE;
        end
      end
      RX_BODY: if (rx_in) begin
        if (rx_idx == LAST_IDX) begin
          rx_tail      = 1'b1;
          rx_state_nxt = RX_IDLE;
          rx_idx_nxt   = '0;
        end else begin
          rx_idx_nxt = rx_idx + IDX_ONE;
        end
      end
      default: begin
        rx_state_nxt = RX_IDLE;
        rx_idx_nxt   = '0;
      end
    endcase
  end

endmodule
